// File: rtl/logic_cmp_pipe.sv
// Two-stage pipelined logic/shift/compare unit with a valid/ready handshake on both sides.
// Optional sticky flag accumulators are enabled by defining LOGIC_CMP_STICKY_EN.
module logic_cmp_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       Logic_opcode,
  input  logic             cmp_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Logic_Out,
  output logic             Logic_za,
  output logic             Logic_zb,
  output logic             Logic_eq,
  output logic             Logic_gt,
  output logic             Logic_lt,
  output logic             Logic_zr,
  output logic             Logic_ill
`ifdef LOGIC_CMP_STICKY_EN
  ,
  input  logic             flag_clr,
  output logic             sticky_eq,
  output logic             sticky_gt,
  output logic             sticky_lt,
  output logic             sticky_ill
`endif
);

  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_NOT1 = 4'b0111;
  localparam logic [3:0] OP_NOT2 = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_XNOR = 4'b1010;
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // Valid never depends on ready; in_ready depends combinationally only on out_ready.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_op1;
  logic [WIDTH-1:0] s1_op2;
  logic [3:0]       s1_opc;
  logic             s1_signed;

  logic             s2_adv;
  logic             accept;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;

  // Stage-2 next values computed from the stage-1 registers
  logic [WIDTH-1:0] res;
  logic [SHW-1:0]   shamt;
  logic             ill_n;
  logic             za_n;
  logic             zb_n;
  logic             eq_n;
  logic             gt_n;
  logic             lt_n;
  logic             zr_n;

  assign shamt = s1_op2[SHW-1:0];

  always_comb begin
    res   = '0;
    ill_n = 1'b0;
    case (s1_opc)
      OP_AND:  res = s1_op1 & s1_op2;
      OP_OR:   res = s1_op1 | s1_op2;
      OP_NOR:  res = ~(s1_op1 | s1_op2);
      OP_NOT1: res = ~s1_op1;
      OP_NOT2: res = ~s1_op2;
      OP_XOR:  res = s1_op1 ^ s1_op2;
      OP_XNOR: res = ~(s1_op1 ^ s1_op2);
      OP_SHL:  res = s1_op1 << shamt;
      OP_SHR:  res = s1_op1 >> shamt;
      OP_SRA:  res = WIDTH'($signed(s1_op1) >>> shamt);
      default: begin
        res   = '0;
        ill_n = 1'b1;
      end
    endcase
  end

  always_comb begin
    za_n = (s1_op1 == '0);
    zb_n = (s1_op2 == '0);
    eq_n = (s1_op1 == s1_op2);
    zr_n = (res == '0);
    if (s1_signed) begin
      gt_n = ($signed(s1_op1) > $signed(s1_op2));
      lt_n = ($signed(s1_op1) < $signed(s1_op2));
    end else begin
      gt_n = (s1_op1 > s1_op2);
      lt_n = (s1_op1 < s1_op2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op1    <= '0;
      s1_op2    <= '0;
      s1_opc    <= '0;
      s1_signed <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_op1    <= op1;
        s1_op2    <= op2;
        s1_opc    <= Logic_opcode;
        s1_signed <= cmp_signed;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Output registers only load on a real transfer so they hold while idle or stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Logic_Out <= '0;
      Logic_za  <= 1'b0;
      Logic_zb  <= 1'b0;
      Logic_eq  <= 1'b0;
      Logic_gt  <= 1'b0;
      Logic_lt  <= 1'b0;
      Logic_zr  <= 1'b0;
      Logic_ill <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Logic_Out <= res;
        Logic_za  <= za_n;
        Logic_zb  <= zb_n;
        Logic_eq  <= eq_n;
        Logic_gt  <= gt_n;
        Logic_lt  <= lt_n;
        Logic_zr  <= zr_n;
        Logic_ill <= ill_n;
      end
    end
  end

`ifdef LOGIC_CMP_STICKY_EN
  logic out_hs;
  assign out_hs = out_valid && out_ready;

  // A clear wipes history, but the flags of a same-cycle handshake still land
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_eq  <= 1'b0;
      sticky_gt  <= 1'b0;
      sticky_lt  <= 1'b0;
      sticky_ill <= 1'b0;
    end else begin
      sticky_eq  <= (sticky_eq  && !flag_clr) || (out_hs && Logic_eq);
      sticky_gt  <= (sticky_gt  && !flag_clr) || (out_hs && Logic_gt);
      sticky_lt  <= (sticky_lt  && !flag_clr) || (out_hs && Logic_lt);
      sticky_ill <= (sticky_ill && !flag_clr) || (out_hs && Logic_ill);
    end
  end
`endif

endmodule

// File: tb/tb_logic_cmp_pipe.sv
// Directed scoreboard bench for logic_cmp_pipe; sticky checks run when LOGIC_CMP_STICKY_EN is defined.
module tb_logic_cmp_pipe;
  localparam int W  = 16;
  localparam int BW = W + 7;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op1;
  logic [W-1:0]  op2;
  logic [3:0]    opcode;
  logic          cmp_signed;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  logic_out;
  logic          za, zb, eq, gt, lt, zr, ill;
`ifdef LOGIC_CMP_STICKY_EN
  logic          flag_clr;
  logic          sticky_eq, sticky_gt, sticky_lt, sticky_ill;
`endif

  logic [BW-1:0] exp_q[$];
  string         name_q[$];
  int            checks;
  int            errors;
  int            rx_count;
  bit            stall_seen;
  bit            prev_stall;
  logic [BW-1:0] prev_bundle;
  logic [BW-1:0] bundle;

  assign bundle = {logic_out, za, zb, eq, gt, lt, zr, ill};

  logic_cmp_pipe #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op1          (op1),
    .op2          (op2),
    .Logic_opcode (opcode),
    .cmp_signed   (cmp_signed),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .Logic_Out    (logic_out),
    .Logic_za     (za),
    .Logic_zb     (zb),
    .Logic_eq     (eq),
    .Logic_gt     (gt),
    .Logic_lt     (lt),
    .Logic_zr     (zr),
    .Logic_ill    (ill)
`ifdef LOGIC_CMP_STICKY_EN
    ,
    .flag_clr     (flag_clr),
    .sticky_eq    (sticky_eq),
    .sticky_gt    (sticky_gt),
    .sticky_lt    (sticky_lt),
    .sticky_ill   (sticky_ill)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [BW-1:0] ex(input logic [W-1:0] o, input logic a_z, input logic b_z,
                                       input logic e, input logic g, input logic l,
                                       input logic r_z, input logic il);
    return {o, a_z, b_z, e, g, l, r_z, il};
  endfunction

  task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] opc,
                      input logic sg, input logic [BW-1:0] e, input string nm);
    int n;
    in_valid   = 1'b1;
    op1        = a;
    op2        = b;
    opcode     = opc;
    cmp_signed = sg;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        break;
      end
      n++;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL %s_accept_timeout: got in_ready=0, required 1", nm);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: got %0d pending, required 0", nm, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (in_valid && !in_ready) stall_seen = 1'b1;
      if (out_valid && out_ready) begin
        rx_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h, required no output", bundle);
        end else begin
          chk(name_q.pop_front(), bundle, exp_q.pop_front());
        end
        prev_stall = 1'b0;
      end else if (out_valid) begin
        if (prev_stall) chk("hold_stable", bundle, prev_bundle);
        prev_stall  = 1'b1;
        prev_bundle = bundle;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  int rx_before;

  initial begin
    checks     = 0;
    errors     = 0;
    rx_count   = 0;
    stall_seen = 1'b0;
    prev_stall = 1'b0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    op1        = '0;
    op2        = '0;
    opcode     = '0;
    cmp_signed = 1'b0;
    out_ready  = 1'b1;
`ifdef LOGIC_CMP_STICKY_EN
    flag_clr   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", bundle, '0);
    chk("reset_out_valid", BW'(out_valid), '0);
    chk("reset_in_ready", BW'(in_ready), BW'(1));
    @(posedge clk);
    #1;

    // OR with exact two-cycle latency
    send(16'h00F0, 16'h0F0F, 4'b0101, 1'b0, ex(16'h0FFF, 0, 0, 0, 0, 1, 0, 0), "or_basic");
    @(negedge clk);
    chk("latency_cycle1", BW'(out_valid), '0);
    @(negedge clk);
    chk("latency_cycle2", BW'(out_valid), BW'(1));
    wait_drain("or_basic");

    // Unsigned vs signed compare
    send(16'h8000, 16'h0001, 4'b1001, 1'b0, ex(16'h8001, 0, 0, 0, 1, 0, 0, 0), "xor_unsigned");
    send(16'h8000, 16'h0001, 4'b1001, 1'b1, ex(16'h8001, 0, 0, 0, 0, 1, 0, 0), "xor_signed");
    send(16'hFFFF, 16'h8000, 4'b0100, 1'b1, ex(16'h8000, 0, 0, 0, 1, 0, 0, 0), "and_signed_negs");
    send(16'h0000, 16'hFFFF, 4'b0101, 1'b1, ex(16'hFFFF, 1, 0, 0, 1, 0, 0, 0), "or_signed_za");

    // Shifts; upper op2 bits ignored
    send(16'h8001, 16'h0011, 4'b1101, 1'b0, ex(16'hC000, 0, 0, 0, 1, 0, 0, 0), "sra_1");
    send(16'h8001, 16'h0011, 4'b1100, 1'b0, ex(16'h4000, 0, 0, 0, 1, 0, 0, 0), "srl_1");
    send(16'h8001, 16'h0011, 4'b1011, 1'b0, ex(16'h0002, 0, 0, 0, 1, 0, 0, 0), "sll_1");
    send(16'h8001, 16'h0010, 4'b1101, 1'b0, ex(16'h8001, 0, 0, 0, 1, 0, 0, 0), "sra_0");
    send(16'h8000, 16'h000F, 4'b1101, 1'b0, ex(16'hFFFF, 0, 0, 0, 1, 0, 0, 0), "sra_15");

    // Remaining bitwise ops
    send(16'hF0F0, 16'hFF00, 4'b0100, 1'b0, ex(16'hF000, 0, 0, 0, 0, 1, 0, 0), "and");
    send(16'h00FF, 16'h0F00, 4'b0110, 1'b0, ex(16'hF000, 0, 0, 0, 0, 1, 0, 0), "nor");
    send(16'hFFFF, 16'hFFFF, 4'b0111, 1'b0, ex(16'h0000, 0, 0, 1, 0, 0, 1, 0), "not_op1");
    send(16'h1234, 16'h00FF, 4'b1000, 1'b0, ex(16'hFF00, 0, 0, 0, 1, 0, 0, 0), "not_op2");
    send(16'hAAAA, 16'h5555, 4'b1010, 1'b1, ex(16'h0000, 0, 0, 0, 0, 1, 1, 0), "xnor_signed");

    // Illegal opcodes
    send(16'h0000, 16'h0000, 4'b1111, 1'b0, ex(16'h0000, 1, 1, 1, 0, 0, 1, 1), "ill_1111");
    send(16'h0005, 16'h0005, 4'b0000, 1'b1, ex(16'h0000, 0, 0, 1, 0, 0, 1, 1), "ill_0000");
    wait_drain("directed");

    // Back-to-back stream with a three-cycle downstream stall
    stall_seen = 1'b0;
    fork
      begin
        send(16'h0001, 16'h0002, 4'b1001, 1'b0, ex(16'h0003, 0, 0, 0, 0, 1, 0, 0), "stream_a");
        send(16'h00FF, 16'h00FF, 4'b1001, 1'b0, ex(16'h0000, 0, 0, 1, 0, 0, 1, 0), "stream_b");
        send(16'hF000, 16'h0004, 4'b1100, 1'b0, ex(16'h0F00, 0, 0, 0, 1, 0, 0, 0), "stream_c");
        send(16'h0003, 16'h0002, 4'b1011, 1'b0, ex(16'h000C, 0, 0, 0, 1, 0, 0, 0), "stream_d");
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("stream");
    chk("stream_in_ready_fell", BW'(stall_seen), BW'(1));

    // Reset while both stages are full
    out_ready = 1'b0;
    send(16'h0001, 16'h0001, 4'b0100, 1'b0, ex(16'h0001, 0, 0, 1, 0, 0, 0, 0), "flush_a");
    send(16'h0002, 16'h0001, 4'b0100, 1'b0, ex(16'h0000, 0, 0, 0, 1, 0, 1, 0), "flush_b");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    name_q.delete();
    rx_before = rx_count;
    @(negedge clk);
    chk("flush_out_valid", BW'(out_valid), '0);
    chk("flush_in_ready", BW'(in_ready), BW'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("flush_no_output", BW'(rx_count - rx_before), '0);

`ifdef LOGIC_CMP_STICKY_EN
    chk("sticky_after_reset", BW'({sticky_eq, sticky_gt, sticky_lt, sticky_ill}), '0);
    send(16'h0003, 16'h0003, 4'b0100, 1'b0, ex(16'h0003, 0, 0, 1, 0, 0, 0, 0), "sticky_eq_txn");
    send(16'h0001, 16'h0002, 4'b0101, 1'b0, ex(16'h0003, 0, 0, 0, 0, 1, 0, 0), "sticky_lt_txn");
    wait_drain("sticky_a");
    chk("sticky_eq_lt", BW'({sticky_eq, sticky_gt, sticky_lt, sticky_ill}), BW'(4'b1010));
    out_ready = 1'b0;
    send(16'h0005, 16'h0003, 4'b1001, 1'b0, ex(16'h0006, 0, 0, 0, 1, 0, 0, 0), "sticky_gt_txn");
    @(posedge clk);
    #1;
    flag_clr  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    chk("sticky_clr_with_gt", BW'({sticky_eq, sticky_gt, sticky_lt, sticky_ill}), BW'(4'b0100));
    wait_drain("sticky_b");
`endif

    chk("queue_empty", BW'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_cmp_pipe.md
Name: logic_cmp_pipe

Overview:
Parametrised, pipelined successor to the CPU's combinational logic/compare unit. Accepts operand pairs over a valid/ready handshake and performs a bitwise operation or barrel shift. It produces registered result and comparison flags two cycles later, with unsigned or signed compare selectable per transaction. It sits between the register-file read stage and the writeback/branch stage.

Parameters:
WIDTH, 16, operand/result width in bits; any value >= 2.
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand/opcode presented.
in_ready  out  1  block can accept this cycle.
op1  in  WIDTH  operand A.
op2  in  WIDTH  operand B.
Logic_opcode  in  4  operation select.
cmp_signed  in  1  1 = two's-complement compare; 0 = unsigned.
out_valid  out  1  result/flags valid.
out_ready  in  1  downstream accepts.
Logic_Out  out  WIDTH  result.
Logic_za, Logic_zb  out  1 each  op1 == 0, op2 == 0.
Logic_eq, Logic_gt, Logic_lt  out  1 each  op1 ==, >, < op2 (per cmp_signed).
Logic_zr  out  1  Logic_Out == 0.
Logic_ill  out  1  opcode not in the table below.

Behaviour:
- Opcodes:
  - 0100 AND; 0101 OR; 0110 NOR; 0111 ~op1; 1000 ~op2; 1001 XOR; 1010 XNOR.
  - 1011 op1 << op2[SHW-1:0]; 1100 logical op1 >> op2[SHW-1:0]; 1101 arithmetic op1 >>> op2[SHW-1:0].
  - Upper bits of op2 are ignored for shifts. Shift by 0 returns op1.
  - Any other opcode: Logic_Out = 0, Logic_ill = 1. All compare/zero flags are still computed normally.
- Pipeline: S1 registers op1, op2, opcode and cmp_signed on accept (in_valid & in_ready). S2 registers the computed result and all flags.
- Latency: exactly 2 clk from accept to out_valid when out_ready is held high. Throughput: 1 transaction/cycle.
- Stall rule:
  - S2 advances when !out_valid | out_ready.
  - S1 advances into S2 under the same condition.
  - in_ready = !s1_valid | (!out_valid | out_ready). in_ready is combinational from out_ready; no other combinational input->output path exists.
- While out_valid & !out_ready, Logic_Out and all flags hold stable. No transaction is dropped or duplicated.
- Flags: exactly one of eq/gt/lt is 1 whenever out_valid. Signed compare treats bit WIDTH-1 as the sign bit.
- Reset (rst = 1 at posedge):
  - s1_valid = out_valid = 0; Logic_Out = 0; all flags = 0.
  - in_ready reads 1 in the cycle after reset.
  - Reset mid-transaction discards all in-flight data; no partial output appears.
- Simultaneous accept and drain in the same cycle are legal; occupancy is unchanged.
- When out_valid = 0, output values are don't-care but must hold their last value (no toggling).

Optional Feature:
LOGIC_CMP_STICKY_EN
- Defined:
  - Adds input flag_clr (1) and outputs sticky_eq, sticky_gt, sticky_lt, sticky_ill (1 each).
  - Each sticky bit ORs in its flag on every output handshake (out_valid & out_ready).
  - flag_clr clears all sticky bits synchronously. If flag_clr and a handshake occur in the same cycle, the clear wins, then that cycle's flags are OR'd in, so the new flags survive.
  - Reset clears all sticky bits.
- Undefined: these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then op1=16'h00F0, op2=16'h0F0F, opcode 0101, out_ready=1 -> two cycles later Logic_Out=16'h0FFF, gt=0, lt=1, za=zb=zr=ill=0.
2. op1=16'h8000, op2=16'h0001, opcode 1001: with cmp_signed=0 -> gt=1; with cmp_signed=1 -> lt=1. Logic_Out=16'h8001 in both cases.
3. Shifts with op1=16'h8001, op2=16'h0011 (amount 1): opcode 1101 -> 16'hC000; 1100 -> 16'h4000; 1011 -> 16'h0002.
4. Back-to-back stream of 4 transactions with out_ready low for 3 cycles mid-stream -> in_ready falls once both stages are full, outputs hold stable, and all 4 results emerge in order with no loss.
5. opcode 1111, op1=op2=0 -> Logic_Out=0, ill=1, eq=1, za=zb=zr=1. Asserting rst while both stages are full -> out_valid=0 next cycle and nothing emerges afterward.
6. With LOGIC_CMP_STICKY_EN defined: complete handshakes producing eq, then lt -> sticky_eq=sticky_lt=1. Assert flag_clr together with a gt handshake -> only sticky_gt=1.
